// File: rtl/clock_core_pkg.sv
// Shared types, field codes and the 24h-to-12h hour conversion for clock_core_param.
package clock_core_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    RUN,
    EDIT_TIME,
    EDIT_ALARM
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_SEC  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_HOUR = 2'd3;

  typedef struct packed {
    bcd_t msd;
    bcd_t lsd;
    logic pm;
  } hour12_t;

  // 00 shows as 12 AM, 12 as 12 PM, 13..23 fold down by twelve.
  function automatic hour12_t to_12h(input bcd_t msd, input bcd_t lsd);
    logic [4:0] h;
    logic [4:0] h12;
    hour12_t    r;
    h = 5'(msd) * 5'd10 + 5'(lsd);
    if (h == 5'd0)
      h12 = 5'd12;
    else if (h > 5'd12)
      h12 = h - 5'd12;
    else
      h12 = h;
    r.pm  = (h >= 5'd12);
    r.msd = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    r.lsd = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
    return r;
  endfunction

endpackage

// File: rtl/clock_core_bcd_mod_counter.sv
// Two-digit BCD counter wrapping modulo MOD (60 or 24); carry is a same-cycle wrap flag.
module bcd_mod_counter
  import clock_core_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  output bcd_t msd_o,
  output bcd_t lsd_o,
  output logic carry_o
);

  localparam bcd_t MAX_MSD = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAX_LSD = bcd_t'((MOD - 1) % 10);

  bcd_t msd_q, msd_d;
  bcd_t lsd_q, lsd_d;
  logic at_max;

  assign at_max  = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
  assign carry_o = inc_i && at_max;
  assign msd_o   = msd_q;
  assign lsd_o   = lsd_q;

  always_comb begin
    msd_d = msd_q;
    lsd_d = lsd_q;
    if (inc_i) begin
      if (at_max) begin
        msd_d = '0;
        lsd_d = '0;
      end else if (lsd_q == 4'd9) begin
        lsd_d = '0;
        msd_d = msd_q + 4'd1;
      end else begin
        lsd_d = lsd_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msd_q <= '0;
      lsd_q <= '0;
    end else begin
      msd_q <= msd_d;
      lsd_q <= lsd_d;
    end
  end

endmodule

// File: rtl/clock_core_param.sv
// HH:MM:SS BCD clock with prescaler, three-button edit FSM and 12/24h display.
// Define CLOCK_CORE_ALARM_EN to add the daily alarm (EDIT_ALARM state and AlarmOut).
module clock_core_param
  import clock_core_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SIM_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Mode12,
  input  logic       BtnMode,
  input  logic       BtnDigit,
  input  logic       BtnValue,
  output logic       Editing,
  output logic [1:0] EditField,
  output logic [3:0] HourMSD,
  output logic [3:0] HourLSD,
  output logic [3:0] MinMSD,
  output logic [3:0] MinLSD,
  output logic [3:0] SecMSD,
  output logic [3:0] SecLSD,
  output logic       PM,
`ifdef CLOCK_CORE_ALARM_EN
  output logic       AlarmOut,
`endif
  output logic       SecondTick
);

  localparam int unsigned TC = CLK_HZ / SIM_DIV - 1;
  localparam int unsigned CW = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [CW-1:0] TC_C = CW'(TC);

  state_t          state_q;
  logic [1:0]      fld_q;
  logic            editing_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;

  logic digit_p, value_p, run_tick;
  logic sec_inc, min_inc, hr_inc;
  logic sec_carry, min_carry, hr_carry;
  bcd_t sec_msd, sec_lsd, min_msd, min_lsd, hr_msd, hr_lsd;

  assign digit_p  = BtnDigit & ~BtnMode;
  assign value_p  = BtnValue & ~BtnMode & ~BtnDigit;
  assign run_tick = (state_q == RUN) && tick_q;

  // Entering edit clears the prescaler on the same edge, so no tick can land in an edit cycle.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (state_q == RUN && !BtnMode) begin
      tick_d = (cnt_q == TC_C);
      cnt_d  = (cnt_q == TC_C) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign SecondTick = tick_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= RUN;
      fld_q     <= FLD_NONE;
      editing_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (BtnMode) begin
            state_q   <= EDIT_TIME;
            fld_q     <= FLD_SEC;
            editing_q <= 1'b1;
          end
        end
        EDIT_TIME: begin
          if (BtnMode) begin
`ifdef CLOCK_CORE_ALARM_EN
            state_q   <= EDIT_ALARM;
            fld_q     <= FLD_MIN;
`else
            state_q   <= RUN;
            fld_q     <= FLD_NONE;
            editing_q <= 1'b0;
`endif
          end else if (digit_p) begin
            fld_q <= (fld_q == FLD_HOUR) ? FLD_SEC : fld_q + 2'd1;
          end
        end
`ifdef CLOCK_CORE_ALARM_EN
        EDIT_ALARM: begin
          if (BtnMode) begin
            state_q   <= RUN;
            fld_q     <= FLD_NONE;
            editing_q <= 1'b0;
          end else if (digit_p) begin
            fld_q <= (fld_q == FLD_MIN) ? FLD_HOUR : FLD_MIN;
          end
        end
`endif
        default: begin
          state_q   <= RUN;
          fld_q     <= FLD_NONE;
          editing_q <= 1'b0;
        end
      endcase
    end
  end

  assign Editing   = editing_q;
  assign EditField = fld_q;

  // Edit increments never carry; only running ticks ripple upward.
  always_comb begin
    sec_inc = run_tick;
    min_inc = run_tick && sec_carry;
    hr_inc  = run_tick && min_carry;
    if (state_q == EDIT_TIME && value_p) begin
      sec_inc = (fld_q == FLD_SEC);
      min_inc = (fld_q == FLD_MIN);
      hr_inc  = (fld_q == FLD_HOUR);
    end
  end

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk_i(CLK), .rst_ni(RST), .inc_i(sec_inc),
    .msd_o(sec_msd), .lsd_o(sec_lsd), .carry_o(sec_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk_i(CLK), .rst_ni(RST), .inc_i(min_inc),
    .msd_o(min_msd), .lsd_o(min_lsd), .carry_o(min_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hour (
    .clk_i(CLK), .rst_ni(RST), .inc_i(hr_inc),
    .msd_o(hr_msd), .lsd_o(hr_lsd), .carry_o(hr_carry)
  );

`ifdef CLOCK_CORE_ALARM_EN
  bcd_t al_min_msd, al_min_lsd, al_hr_msd, al_hr_lsd;
  logic al_min_carry, al_hr_carry;
  logic al_val, match, armed_q, match_q, alarm_q;
  logic unused_carries;

  assign al_val = (state_q == EDIT_ALARM) && value_p;

  bcd_mod_counter #(.MOD(60)) u_al_min (
    .clk_i(CLK), .rst_ni(RST), .inc_i(al_val && fld_q == FLD_MIN),
    .msd_o(al_min_msd), .lsd_o(al_min_lsd), .carry_o(al_min_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_al_hour (
    .clk_i(CLK), .rst_ni(RST), .inc_i(al_val && fld_q == FLD_HOUR),
    .msd_o(al_hr_msd), .lsd_o(al_hr_lsd), .carry_o(al_hr_carry)
  );

  assign unused_carries = ^{hr_carry, al_min_carry, al_hr_carry};

  assign match = (state_q == RUN) && armed_q &&
                 ({hr_msd, hr_lsd} == {al_hr_msd, al_hr_lsd}) &&
                 ({min_msd, min_lsd} == {al_min_msd, al_min_lsd}) &&
                 ({sec_msd, sec_lsd} == 8'h00);

  // Rising edge of the match so a cleared alarm stays cleared for the rest of HH:MM:00.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed_q <= 1'b0;
      match_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      match_q <= match;
      if (state_q == EDIT_ALARM && BtnMode)
        armed_q <= 1'b1;
      if (BtnMode || BtnDigit || BtnValue || (run_tick && sec_carry))
        alarm_q <= 1'b0;
      else if (match && !match_q)
        alarm_q <= 1'b1;
    end
  end

  assign AlarmOut = alarm_q;
`else
  logic unused_carries;
  assign unused_carries = hr_carry;
`endif

  bcd_t    dh_m, dh_l, dm_m, dm_l, ds_m, ds_l;
  hour12_t h12;

  always_comb begin
    dh_m = hr_msd;
    dh_l = hr_lsd;
    dm_m = min_msd;
    dm_l = min_lsd;
    ds_m = sec_msd;
    ds_l = sec_lsd;
`ifdef CLOCK_CORE_ALARM_EN
    if (state_q == EDIT_ALARM) begin
      dh_m = al_hr_msd;
      dh_l = al_hr_lsd;
      dm_m = al_min_msd;
      dm_l = al_min_lsd;
      ds_m = '0;
      ds_l = '0;
    end
`endif
    h12 = to_12h(dh_m, dh_l);
    if (Mode12) begin
      HourMSD = h12.msd;
      HourLSD = h12.lsd;
      PM      = h12.pm;
    end else begin
      HourMSD = dh_m;
      HourLSD = dh_l;
      PM      = 1'b0;
    end
    MinMSD = dm_m;
    MinLSD = dm_l;
    SecMSD = ds_m;
    SecLSD = ds_l;
  end

endmodule
